// File: rtl/encode_display.sv
`default_nettype none
// ============================================================================
// Module   : encode_display
// Purpose  : 7-input active-low priority encoder with active-low enable.
//            The encoded value is mirrored to two multiplexed 4-digit
//            seven-segment groups: the right group shows it in decimal,
//            the left group shows it in binary with a leading 'b'.
//            The raw switch state is echoed on the board LEDs.
// Ports    : clk          - system clock, rising edge
//            rst          - synchronous active-high reset
//            n_EN         - encoder enable, active low
//            Datain[6:0]  - request lines, active low, bit i = request i+1
//            switch_led   - [6:0] Datain echo, [7] enabled indicator
//            a_to_g_left  - left segments {a,b,c,d,e,f,g,dp}, active high
//            a_to_g_right - right segments, same format
//            leftseg      - left digit select, one-hot, bit3 = leftmost
//            rightseg     - right digit select, one-hot, bit3 = leftmost
// Revision : 1.0 - initial release
// ============================================================================
module encode_display #(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       n_EN,
    input  logic [6:0] Datain,
    output logic [7:0] switch_led,
    output logic [7:0] a_to_g_left,
    output logic [7:0] a_to_g_right,
    output logic [3:0] leftseg,
    output logic [3:0] rightseg
);

    localparam int                 c_CNT_W     = $clog2(SCAN_DIV);
    localparam logic [c_CNT_W-1:0] c_SCAN_LAST = c_CNT_W'(SCAN_DIV - 1);

    localparam logic [7:0] c_SEG_0     = 8'hFC;
    localparam logic [7:0] c_SEG_1     = 8'h60;
    localparam logic [7:0] c_SEG_B     = 8'h3E;
    localparam logic [7:0] c_SEG_DASH  = 8'h02;
    localparam logic [7:0] c_SEG_BLANK = 8'h00;

    // Stage 1: registered inputs
    logic               r_nen_s1;
    logic [6:0]         r_data_s1;
    // Stage 2: registered encoder result
    logic               r_en_s2;
    logic [2:0]         r_code_s2;
    // LED echo
    logic [7:0]         r_switch_led;
    // Scan prescaler and digit index
    logic [c_CNT_W-1:0] r_scan_cnt;
    logic [1:0]         r_digit;
    // Output registers: selects and glyphs move together
    logic [3:0]         r_sel;
    logic [7:0]         r_seg_left;
    logic [7:0]         r_seg_right;

    logic [2:0]         w_code;
    logic [3:0]         w_sel;
    logic [7:0]         w_seg_left;
    logic [7:0]         w_seg_right;

    function automatic logic [7:0] dec_glyph(input logic [2:0] v);
        logic [7:0] g;
        g = c_SEG_BLANK;
        case (v)
            3'd0: g = 8'hFC;
            3'd1: g = 8'h60;
            3'd2: g = 8'hDA;
            3'd3: g = 8'hF2;
            3'd4: g = 8'h66;
            3'd5: g = 8'hB6;
            3'd6: g = 8'hBE;
            3'd7: g = 8'hE0;
            default: g = c_SEG_BLANK;
        endcase
        return g;
    endfunction

    // Priority encoder: ascending scan so the highest active request wins.
    always_comb begin
        w_code = 3'd0;
        if (!r_nen_s1) begin
            for (int i = 0; i < 7; i++) begin
                if (!r_data_s1[i]) begin
                    w_code = 3'(i + 1);
                end
            end
        end
    end

    // Glyph selection for the digit currently being scanned.
    always_comb begin
        w_sel       = 4'b0001 << r_digit;
        w_seg_left  = c_SEG_DASH;
        w_seg_right = c_SEG_BLANK;
        if (r_en_s2) begin
            if (r_digit == 2'd3) begin
                w_seg_left = c_SEG_B;
            end else begin
                w_seg_left = r_code_s2[r_digit] ? c_SEG_1 : c_SEG_0;
            end
            if (r_digit == 2'd0) begin
                w_seg_right = dec_glyph(r_code_s2);
            end
        end else if (r_digit == 2'd0) begin
            w_seg_right = c_SEG_DASH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nen_s1     <= 1'b0;
            r_data_s1    <= 7'd0;
            r_en_s2      <= 1'b0;
            r_code_s2    <= 3'd0;
            r_switch_led <= 8'd0;
            r_scan_cnt   <= '0;
            r_digit      <= 2'd0;
            r_sel        <= 4'd0;
            r_seg_left   <= 8'd0;
            r_seg_right  <= 8'd0;
        end else begin
            r_nen_s1     <= n_EN;
            r_data_s1    <= Datain;
            r_switch_led <= {~r_nen_s1, r_data_s1};
            r_en_s2      <= ~r_nen_s1;
            r_code_s2    <= w_code;
            if (r_scan_cnt == c_SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_digit    <= r_digit + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + c_CNT_W'(1);
            end
            r_sel        <= w_sel;
            r_seg_left   <= w_seg_left;
            r_seg_right  <= w_seg_right;
        end
    end

    assign switch_led   = r_switch_led;
    assign a_to_g_left  = r_seg_left;
    assign a_to_g_right = r_seg_right;
    assign leftseg      = r_sel;
    assign rightseg     = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_encode_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_encode_display
// Purpose  : Self-checking bench for encode_display. A driver applies
//            directed and random stimulus and pushes the expected outputs
//            for every clock edge into a queue; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encode_display;

    localparam int SCAN_DIV = 4;

    localparam logic [7:0] c_GLYPH [8] = '{8'hFC, 8'h60, 8'hDA, 8'hF2,
                                           8'h66, 8'hB6, 8'hBE, 8'hE0};

    logic       clk = 1'b1;
    logic       rst = 1'b1;
    logic       n_EN = 1'b1;
    logic [6:0] Datain = 7'h7F;
    logic [7:0] switch_led;
    logic [7:0] a_to_g_left;
    logic [7:0] a_to_g_right;
    logic [3:0] leftseg;
    logic [3:0] rightseg;

    always #5 clk = ~clk;

    encode_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .n_EN         (n_EN),
        .Datain       (Datain),
        .switch_led   (switch_led),
        .a_to_g_left  (a_to_g_left),
        .a_to_g_right (a_to_g_right),
        .leftseg      (leftseg),
        .rightseg     (rightseg)
    );

    typedef struct packed {
        logic       rst;
        logic       nen;
        logic [6:0] data;
    } stim_t;

    typedef struct packed {
        logic [7:0] led;
        logic [7:0] left;
        logic [7:0] right;
        logic [3:0] lsel;
        logic [3:0] rsel;
    } exp_t;

    exp_t  exp_q [$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_fail   = 0;

    // Reference model state, owned by the driver
    stim_t p1 = '{1'b1, 1'b0, 7'd0};
    stim_t p2 = '{1'b1, 1'b0, 7'd0};
    int    m_n = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h, required %h at t=%0t", name, act, req, $time);
        end
    endtask

    // Highest active-low request index + 1, zero when disabled or idle.
    function automatic logic [2:0] prio(input logic nen, input logic [6:0] d);
        if (nen) return 3'd0;
        for (int i = 6; i >= 0; i--)
            if (d[i] == 1'b0) return 3'(i + 1);
        return 3'd0;
    endfunction

    // Expected outputs right after an edge, given the input sampled at that
    // edge (rst_now) and at the two edges before it (q1, q2).
    function automatic exp_t model(input logic rst_now, input stim_t q1,
                                   input stim_t q2, input int n);
        exp_t       e;
        int         digit;
        logic       en;
        logic [2:0] code;
        stim_t      s1a, s1b;
        e = '0;
        if (rst_now) return e;
        digit  = (n / SCAN_DIV) % 4;
        e.lsel = 4'(1 << digit);
        e.rsel = e.lsel;
        // A reset edge leaves the input register holding zeros.
        s1a = q1.rst ? stim_t'(0) : q1;
        s1b = q2.rst ? stim_t'(0) : q2;
        e.led = {~s1a.nen, s1a.data};
        if (q1.rst) begin
            en   = 1'b0;
            code = 3'd0;
        end else begin
            en   = ~s1b.nen;
            code = prio(s1b.nen, s1b.data);
        end
        if (!en) begin
            e.left  = 8'h02;
            e.right = (digit == 0) ? 8'h02 : 8'h00;
        end else begin
            e.left  = (digit == 3) ? 8'h3E : c_GLYPH[{2'b00, code[digit]}];
            e.right = (digit == 0) ? c_GLYPH[code] : 8'h00;
        end
        return e;
    endfunction

    task automatic step(input logic r, input logic ne, input logic [6:0] d);
        @(negedge clk);
        rst    = r;
        n_EN   = ne;
        Datain = d;
        exp_q.push_back(model(r, p1, p2, m_n));
        if (r) m_n = 0;
        else   m_n++;
        p2 = p1;
        p1 = '{r, ne, d};
    endtask

    task automatic hold(input logic ne, input logic [6:0] d, input int cycles);
        for (int k = 0; k < cycles; k++) step(1'b0, ne, d);
    endtask

    // Monitor: one expected record per clock edge
    exp_t mon_e;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("switch_led",   switch_led,          mon_e.led);
                check("a_to_g_left",  a_to_g_left,         mon_e.left);
                check("a_to_g_right", a_to_g_right,        mon_e.right);
                check("leftseg",      {4'd0, leftseg},     {4'd0, mon_e.lsel});
                check("rightseg",     {4'd0, rightseg},    {4'd0, mon_e.rsel});
            end
        end
    end

    // Driver
    initial begin
        logic [6:0] d;
        int         guard;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 7'h7F);

        // Enabled, no request, then each request alone
        hold(1'b0, 7'h7F, 20);
        for (int i = 0; i < 7; i++) begin
            d    = 7'h7F;
            d[i] = 1'b0;
            hold(1'b0, d, 20);
        end

        // Highest request wins
        hold(1'b0, 7'b0111110, 20);

        // Disabled with arbitrary requests
        hold(1'b1, 7'b0111110, 20);
        hold(1'b1, 7'($urandom), 20);

        // Random changes landing at arbitrary points inside scan slots
        for (int k = 0; k < 250; k++) begin
            d = ($urandom_range(0, 4) == 0) ? 7'h7F : 7'($urandom);
            hold(($urandom_range(0, 3) == 0), d, $urandom_range(1, 6));
        end

        // Reset while the third digit is being scanned
        guard = 0;
        while ((((m_n / SCAN_DIV) % 4) != 2 || (m_n % SCAN_DIV) != 1) && guard < 64) begin
            step(1'b0, 1'b0, 7'b1011110);
            guard++;
        end
        check("reach_digit2", 8'(((m_n / SCAN_DIV) % 4)), 8'd2);
        step(1'b1, 1'b0, 7'b1011110);
        hold(1'b0, 7'b1011110, 24);

        // Random phase with occasional resets
        for (int k = 0; k < 100; k++) begin
            if ($urandom_range(0, 19) == 0) step(1'b1, 1'b0, 7'h7F);
            hold(($urandom_range(0, 3) == 0), 7'($urandom), $urandom_range(1, 8));
        end

        @(posedge clk);
        @(posedge clk);
        #2;
        check("queue_drain", 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
